uart_cmd_ctrl: RTL and testbench

Command controller sitting between the UART RX/TX FIFO pair and the stopwatch/clock logic. Pops received bytes from the RX FIFO one at a time, decodes single-character ASCII commands into one-cycle command pulses, and writes an echo/acknowledge response into the TX FIFO. It owns the RX FIFO read port and the TX FIFO write port whenever the UART is in command mode.

---
 rtl/uart_cmd_pkg.sv | 52 +++++
 rtl/uart_cmd_decode.sv | 46 ++++
 rtl/uart_cmd_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
//
// Shared definitions for the UART command controller:
//   - ASCII constants for the recognised command letters (both cases), the
//     ignored whitespace bytes and the '?' error response.
//   - Controller state encoding.
//   - One-hot command vector carried from the decoder to the FSM.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    // Command letters, uppercase
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_U    = 8'h55;
    localparam logic [7:0] ASCII_D    = 8'h44;

    // Command letters, lowercase
    localparam logic [7:0] ASCII_R_LC = 8'h72;
    localparam logic [7:0] ASCII_C_LC = 8'h63;
    localparam logic [7:0] ASCII_M_LC = 8'h6D;
    localparam logic [7:0] ASCII_U_LC = 8'h75;
    localparam logic [7:0] ASCII_D_LC = 8'h64;

    // Framing / filler bytes and the error response
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_QM   = 8'h3F;

    // Controller states; explicit codes keep the encoding stable for
    // anything that probes the state register.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_EXEC = 3'd2,
        ST_TX0  = 3'd3,
        ST_TX1  = 3'd4,
        ST_TX2  = 3'd5
    } state_e;

    // One-hot command vector, at most one field set
    typedef struct packed {
        logic run;
        logic clear;
        logic mode;
        logic up;
        logic down;
    } cmd_oh_t;

endpackage : uart_cmd_pkg

// File: rtl/uart_cmd_decode.sv
// -----------------------------------------------------------------------------
// uart_cmd_decode
//
// Purely combinational classifier for one received byte.
//
// Parameters:
//   CASE_FOLD  1 = lowercase r/c/m/u/d also decode as commands
//
// Ports:
//   data       in   8  byte to classify
//   cmd        out  5  one-hot command (all zero when not a command)
//   is_cmd     out  1  byte is a recognised command letter
//   is_ignore  out  1  byte is CR, LF or space (silently dropped)
// -----------------------------------------------------------------------------
module uart_cmd_decode
    import uart_cmd_pkg::*;
#(
    parameter bit CASE_FOLD = 1'b1
) (
    input  logic [7:0] data,
    output cmd_oh_t    cmd,
    output logic       is_cmd,
    output logic       is_ignore
);

    always_comb begin
        cmd = '0;
        case (data)
            ASCII_R:    cmd.run   = 1'b1;
            ASCII_C:    cmd.clear = 1'b1;
            ASCII_M:    cmd.mode  = 1'b1;
            ASCII_U:    cmd.up    = 1'b1;
            ASCII_D:    cmd.down  = 1'b1;
            ASCII_R_LC: cmd.run   = CASE_FOLD;
            ASCII_C_LC: cmd.clear = CASE_FOLD;
            ASCII_M_LC: cmd.mode  = CASE_FOLD;
            ASCII_U_LC: cmd.up    = CASE_FOLD;
            ASCII_D_LC: cmd.down  = CASE_FOLD;
            default:    cmd       = '0;
        endcase

        is_cmd    = |cmd;
        is_ignore = (data == ASCII_CR) || (data == ASCII_LF) || (data == ASCII_SP);
    end

endmodule : uart_cmd_decode

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Command controller between the UART RX/TX FIFOs and the stopwatch logic.
// Pops one byte at a time from the RX FIFO, turns single-letter commands into
// one-cycle pulses and (optionally) echoes the letter, or '?' for an unknown
// byte, followed by CR LF into the TX FIFO.
//
// Parameters:
//   ECHO_EN    1 = write response bytes to the TX FIFO, 0 = never write
//   CASE_FOLD  1 = lowercase command letters accepted
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   rx_empty   in   1  RX FIFO empty
//   rx_rdata   in   8  RX FIFO head byte (show-ahead)
//   rx_re      out  1  RX FIFO pop strobe
//   tx_full    in   1  TX FIFO full
//   tx_we      out  1  TX FIFO write strobe
//   tx_wdata   out  8  TX FIFO write data
//   cmd_run    out  1  'R' pulse
//   cmd_clear  out  1  'C' pulse
//   cmd_mode   out  1  'M' pulse
//   cmd_up     out  1  'U' pulse
//   cmd_down   out  1  'D' pulse
//   err_cnt    out  8  unknown-byte count, saturating at 255
//   busy       out  1  FSM not idle
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter bit ECHO_EN   = 1'b1,
    parameter bit CASE_FOLD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_rdata,
    output logic       rx_re,
    input  logic       tx_full,
    output logic       tx_we,
    output logic [7:0] tx_wdata,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic [7:0] err_cnt,
    output logic       busy
);

    state_e     state;
    logic [7:0] cap;
    logic [7:0] err_q;

    cmd_oh_t    dec_cmd;
    logic       dec_is_cmd;
    logic       dec_is_ignore;
    logic       in_exec;
    logic       in_tx;

    // Saturating 8-bit increment for the error counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode works on the captured byte only, so nothing downstream sees
    // rx_rdata combinationally.
    uart_cmd_decode #(
        .CASE_FOLD (CASE_FOLD)
    ) u_decode (
        .data      (cap),
        .cmd       (dec_cmd),
        .is_cmd    (dec_is_cmd),
        .is_ignore (dec_is_ignore)
    );

    // Control FSM, capture register and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cap   <= 8'h00;
            err_q <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        cap   <= rx_rdata;
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_is_ignore) begin
                        state <= ST_IDLE;
                    end else begin
                        if (!dec_is_cmd) begin
                            err_q <= sat_inc8(err_q);
                        end
                        state <= ECHO_EN ? ST_TX0 : ST_IDLE;
                    end
                end
                // Each TX state holds until its byte is actually accepted
                ST_TX0:  if (!tx_full) state <= ST_TX1;
                ST_TX1:  if (!tx_full) state <= ST_TX2;
                ST_TX2:  if (!tx_full) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state/cap; tx_full only gates tx_we
    always_comb begin
        in_exec  = (state == ST_EXEC);
        in_tx    = (state == ST_TX0) || (state == ST_TX1) || (state == ST_TX2);

        tx_wdata = 8'h00;
        case (state)
            ST_TX0:  tx_wdata = dec_is_cmd ? cap : ASCII_QM;
            ST_TX1:  tx_wdata = ASCII_CR;
            ST_TX2:  tx_wdata = ASCII_LF;
            default: tx_wdata = 8'h00;
        endcase

        rx_re     = (state == ST_POP);
        tx_we     = in_tx && !tx_full;
        cmd_run   = in_exec && dec_cmd.run;
        cmd_clear = in_exec && dec_cmd.clear;
        cmd_mode  = in_exec && dec_cmd.mode;
        cmd_up    = in_exec && dec_cmd.up;
        cmd_down  = in_exec && dec_cmd.down;
        busy      = (state != ST_IDLE);
        err_cnt   = err_q;
    end

endmodule : uart_cmd_ctrl

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Three controller instances: main (echo, case fold), nofold (echo, no fold)
// and noecho (no echo, case fold), each fed by its own RX FIFO model.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance
    logic       rx_empty0 = 1'b1;
    logic [7:0] rx_rdata0 = 8'h00;
    logic       tx_full0;
    logic       rx_re0, tx_we0, run0, clear0, mode0, up0, down0, busy0;
    logic [7:0] tx_wdata0, err0;
    // nofold instance
    logic       rx_empty1 = 1'b1;
    logic [7:0] rx_rdata1 = 8'h00;
    logic       tx_full1;
    logic       rx_re1, tx_we1, run1, clear1, mode1, up1, down1, busy1;
    logic [7:0] tx_wdata1, err1;
    // noecho instance
    logic       rx_empty2 = 1'b1;
    logic [7:0] rx_rdata2 = 8'h00;
    logic       tx_full2;
    logic       rx_re2, tx_we2, run2, clear2, mode2, up2, down2, busy2;
    logic [7:0] tx_wdata2, err2;

    uart_cmd_ctrl #(.ECHO_EN(1'b1), .CASE_FOLD(1'b1)) u_main (
        .clk(clk), .rst(rst), .rx_empty(rx_empty0), .rx_rdata(rx_rdata0), .rx_re(rx_re0),
        .tx_full(tx_full0), .tx_we(tx_we0), .tx_wdata(tx_wdata0),
        .cmd_run(run0), .cmd_clear(clear0), .cmd_mode(mode0), .cmd_up(up0), .cmd_down(down0),
        .err_cnt(err0), .busy(busy0));

    uart_cmd_ctrl #(.ECHO_EN(1'b1), .CASE_FOLD(1'b0)) u_nofold (
        .clk(clk), .rst(rst), .rx_empty(rx_empty1), .rx_rdata(rx_rdata1), .rx_re(rx_re1),
        .tx_full(tx_full1), .tx_we(tx_we1), .tx_wdata(tx_wdata1),
        .cmd_run(run1), .cmd_clear(clear1), .cmd_mode(mode1), .cmd_up(up1), .cmd_down(down1),
        .err_cnt(err1), .busy(busy1));

    uart_cmd_ctrl #(.ECHO_EN(1'b0), .CASE_FOLD(1'b1)) u_noecho (
        .clk(clk), .rst(rst), .rx_empty(rx_empty2), .rx_rdata(rx_rdata2), .rx_re(rx_re2),
        .tx_full(tx_full2), .tx_we(tx_we2), .tx_wdata(tx_wdata2),
        .cmd_run(run2), .cmd_clear(clear2), .cmd_mode(mode2), .cmd_up(up2), .cmd_down(down2),
        .err_cnt(err2), .busy(busy2));

    // RX FIFO models: pop on the edge that samples rx_re, present the new
    // head on the following falling edge.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    always @(posedge clk) begin
        if (rx_re0 && q0.size() > 0) q0.delete(0);
        if (rx_re1 && q1.size() > 0) q1.delete(0);
        if (rx_re2 && q2.size() > 0) q2.delete(0);
    end

    always @(negedge clk) begin
        rx_empty0 = (q0.size() == 0);
        rx_rdata0 = (q0.size() > 0) ? q0[0] : 8'h00;
        rx_empty1 = (q1.size() == 0);
        rx_rdata1 = (q1.size() > 0) ? q1[0] : 8'h00;
        rx_empty2 = (q2.size() == 0);
        rx_rdata2 = (q2.size() > 0) ? q2[0] : 8'h00;
    end

    // Scoreboard and counters
    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    logic [4:0] cmd_exp [$];
    logic [7:0] tx_exp  [$];
    int err_model = 0;
    int rx_cnt0 = 0, tx_cnt0 = 0, cmd_cnt0 = 0;
    int tx_cnt1 = 0, q_cnt1 = 0, cmd_cnt1 = 0;
    int tx_cnt2 = 0, cmd_cnt2 = 0;
    int rx_times [$];

    // Reference classifier: fold lowercase to uppercase, then match
    function automatic logic [4:0] model_cmd(input logic [7:0] b, input bit fold);
        logic [7:0] u;
        u = (fold && b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
        case (u)
            8'h52:   return 5'b10000;
            8'h43:   return 5'b01000;
            8'h4D:   return 5'b00100;
            8'h55:   return 5'b00010;
            8'h44:   return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic bit model_ignore(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
    endfunction

    // Push a byte into the main FIFO and its expected effects into the scoreboard
    task automatic send0(input logic [7:0] b);
        logic [4:0] c;
        c = model_cmd(b, 1'b1);
        q0.push_back(b);
        if (c != 5'b0) begin
            cmd_exp.push_back(c);
            tx_exp.push_back(b);
            tx_exp.push_back(8'h0D);
            tx_exp.push_back(8'h0A);
        end else if (!model_ignore(b)) begin
            if (err_model < 255) err_model++;
            tx_exp.push_back(8'h3F);
            tx_exp.push_back(8'h0D);
            tx_exp.push_back(8'h0A);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] oh;
        logic [4:0] e;
        logic [7:0] d;
        cyc++;
        if (!rst) begin
            oh = {run0, clear0, mode0, up0, down0};
            if (rx_re0) begin
                rx_cnt0++;
                rx_times.push_back(cyc);
            end
            if (oh != 5'b0) begin
                cmd_cnt0++;
                checks++;
                if (cmd_exp.size() == 0) begin
                    $display("FAIL sb_cmd: pulse %b seen, none required", oh);
                end else begin
                    e = cmd_exp.pop_front();
                    if (oh !== e) $display("FAIL sb_cmd: pulse %b, required %b", oh, e);
                    else passes++;
                end
            end
            if (tx_we0) begin
                tx_cnt0++;
                checks++;
                if (tx_exp.size() == 0) begin
                    $display("FAIL sb_tx: write %h seen, none required", tx_wdata0);
                end else begin
                    d = tx_exp.pop_front();
                    if (tx_wdata0 !== d) $display("FAIL sb_tx: write %h, required %h", tx_wdata0, d);
                    else passes++;
                end
            end
            if (tx_we1) begin
                tx_cnt1++;
                if (tx_wdata1 == 8'h3F) q_cnt1++;
            end
            if ({run1, clear1, mode1, up1, down1} != 5'b0) cmd_cnt1++;
            if (tx_we2) tx_cnt2++;
            if ({run2, clear2, mode2, up2, down2} != 5'b0) cmd_cnt2++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Wait until the chosen instance has drained its FIFO and gone idle
    task automatic wait_idle(input int inst, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (inst == 0 && q0.size() == 0 && !busy0) begin ok = 1'b1; break; end
            if (inst == 1 && q1.size() == 0 && !busy1) begin ok = 1'b1; break; end
            if (inst == 2 && q2.size() == 0 && !busy2) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_idle(input int inst, input int limit, input string name);
        bit ok;
        wait_idle(inst, limit, ok);
        checks++;
        if (!ok) $display("FAIL %s_timeout: instance %0d still busy after %0d cycles, required idle", name, inst, limit);
        else passes++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_re0, tx_we0, run0, clear0, mode0, up0, down0, busy0} !== 8'h00)
            $display("FAIL reset_ctl: outputs %b, required 00000000",
                     {rx_re0, tx_we0, run0, clear0, mode0, up0, down0, busy0});
        else passes++;
        checks++;
        if (tx_wdata0 !== 8'h00) $display("FAIL reset_wdata: %h, required 00", tx_wdata0);
        else passes++;
        checks++;
        if (err0 !== 8'h00) $display("FAIL reset_err: %h, required 00", err0);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        // columns: rx_re, cmd_run, tx_we, busy
        logic [3:0] exp_v [6];
        logic [7:0] exp_d [6];
        logic [3:0] got;
        exp_v = '{4'b1001, 4'b0101, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
        exp_d = '{8'h00, 8'h00, 8'h52, 8'h0D, 8'h0A, 8'h00};
        sync();
        send0(8'h52);
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            got = {rx_re0, run0, tx_we0, busy0};
            checks++;
            if (got !== exp_v[k]) $display("FAIL latency_N+%0d: rx_re/run/tx_we/busy %b, required %b", k + 1, got, exp_v[k]);
            else passes++;
            if (exp_v[k][1]) begin
                checks++;
                if (tx_wdata0 !== exp_d[k]) $display("FAIL latency_data_N+%0d: %h, required %h", k + 1, tx_wdata0, exp_d[k]);
                else passes++;
            end
        end
        check_idle(0, 50, "latency");
    endtask

    task automatic test_casefold();
        sync();
        send0(8'h63);
        send0(8'h78);
        send0(8'h64);
        check_idle(0, 100, "fold");
        checks++;
        if (err0 !== 8'(err_model)) $display("FAIL fold_err: %0d, required %0d", err0, err_model);
        else passes++;
        sync();
        q1.push_back(8'h63);
        q1.push_back(8'h78);
        q1.push_back(8'h64);
        check_idle(1, 100, "nofold");
        checks++;
        if (q_cnt1 != 3) $display("FAIL nofold_qm: %0d '?' writes, required 3", q_cnt1);
        else passes++;
        checks++;
        if (tx_cnt1 != 9) $display("FAIL nofold_tx: %0d writes, required 9", tx_cnt1);
        else passes++;
        checks++;
        if (cmd_cnt1 != 0) $display("FAIL nofold_cmd: %0d pulses, required 0", cmd_cnt1);
        else passes++;
        checks++;
        if (err1 !== 8'd3) $display("FAIL nofold_err: %0d, required 3", err1);
        else passes++;
    endtask

    task automatic test_ignore();
        int rx_b, tx_b, cmd_b;
        logic [7:0] err_b;
        rx_b = rx_cnt0; tx_b = tx_cnt0; cmd_b = cmd_cnt0; err_b = err0;
        sync();
        send0(8'h0D);
        send0(8'h20);
        send0(8'h0A);
        check_idle(0, 100, "ignore");
        checks++;
        if (rx_cnt0 - rx_b != 3) $display("FAIL ignore_rx: %0d pops, required 3", rx_cnt0 - rx_b);
        else passes++;
        checks++;
        if (tx_cnt0 != tx_b) $display("FAIL ignore_tx: %0d writes, required 0", tx_cnt0 - tx_b);
        else passes++;
        checks++;
        if (cmd_cnt0 != cmd_b) $display("FAIL ignore_cmd: %0d pulses, required 0", cmd_cnt0 - cmd_b);
        else passes++;
        checks++;
        if (err0 !== err_b) $display("FAIL ignore_err: %0d, required %0d", err0, err_b);
        else passes++;
    endtask

    task automatic test_backpressure();
        bit seen;
        int tx_b;
        seen = 1'b0;
        sync();
        send0(8'h4D);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_we0 && tx_wdata0 == 8'h4D) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) $display("FAIL bp_tx0: echo of 4d not seen, required within 20 cycles");
        else passes++;
        @(posedge clk);
        #1;
        tx_full0 = 1'b1;
        tx_b = tx_cnt0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx_we0 !== 1'b0) $display("FAIL bp_stall_%0d: tx_we %b, required 0", i, tx_we0);
            else passes++;
        end
        tx_full0 = 1'b0;
        check_idle(0, 50, "bp");
        checks++;
        if (tx_cnt0 - tx_b != 2) $display("FAIL bp_count: %0d writes after release, required 2", tx_cnt0 - tx_b);
        else passes++;
    endtask

    task automatic test_back_to_back();
        rx_times.delete();
        sync();
        send0(8'h52);
        send0(8'h55);
        send0(8'h44);
        send0(8'h4D);
        check_idle(0, 100, "b2b");
        checks++;
        if (rx_times.size() != 4) $display("FAIL b2b_pops: %0d pops, required 4", rx_times.size());
        else passes++;
        for (int i = 1; i < rx_times.size(); i++) begin
            checks++;
            if (rx_times[i] - rx_times[i-1] != 6)
                $display("FAIL b2b_spacing_%0d: %0d cycles, required 6", i, rx_times[i] - rx_times[i-1]);
            else passes++;
        end
    endtask

    task automatic test_saturate();
        sync();
        for (int i = 0; i < 255; i++) q2.push_back(8'h78);
        check_idle(2, 2000, "sat255");
        checks++;
        if (err2 !== 8'd255) $display("FAIL sat_at255: %0d, required 255", err2);
        else passes++;
        sync();
        for (int i = 0; i < 45; i++) q2.push_back(8'h5A);
        q2.push_back(8'h52);
        q2.push_back(8'h75);
        check_idle(2, 1000, "sat300");
        checks++;
        if (err2 !== 8'd255) $display("FAIL sat_hold: %0d, required 255", err2);
        else passes++;
        checks++;
        if (tx_cnt2 != 0) $display("FAIL noecho_tx: %0d writes, required 0", tx_cnt2);
        else passes++;
        checks++;
        if (cmd_cnt2 != 2) $display("FAIL noecho_cmd: %0d pulses, required 2", cmd_cnt2);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        sync();
        send0(8'h55);
        send0(8'h44);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_we0 && tx_wdata0 == 8'h55) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) $display("FAIL rstmid_tx0: echo of 55 not seen, required within 20 cycles");
        else passes++;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_re0, tx_we0, run0, clear0, mode0, up0, down0, busy0} !== 8'h00)
            $display("FAIL rstmid_ctl: outputs %b, required 00000000",
                     {rx_re0, tx_we0, run0, clear0, mode0, up0, down0, busy0});
        else passes++;
        checks++;
        if (tx_wdata0 !== 8'h00 || err0 !== 8'h00)
            $display("FAIL rstmid_data: wdata %h err %h, required 00 00", tx_wdata0, err0);
        else passes++;
        // The interrupted CR LF is abandoned; only 'D' and its framing remain.
        tx_exp.delete();
        tx_exp.push_back(8'h44);
        tx_exp.push_back(8'h0D);
        tx_exp.push_back(8'h0A);
        err_model = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check_idle(0, 100, "rstmid");
        checks++;
        if (tx_exp.size() != 0 || cmd_exp.size() != 0)
            $display("FAIL rstmid_drain: %0d tx and %0d cmd pending, required 0 0", tx_exp.size(), cmd_exp.size());
        else passes++;
    endtask

    initial begin
        rst      = 1'b1;
        tx_full0 = 1'b0;
        tx_full1 = 1'b0;
        tx_full2 = 1'b0;
        test_reset();
        test_latency();
        test_casefold();
        test_ignore();
        test_backpressure();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_uart_cmd_ctrl
